// File: rtl/controle_busca_pkg.sv
`default_nettype none
// ============================================================================
// Module      : controle_busca_pkg
// Description : Shared definitions for the instruction fetch controller:
//               FSM state encoding, default widths/depth, PC step.
// Revision    : 1.0 - initial release
// ============================================================================
package controle_busca_pkg;

  localparam int XLEN      = 32;
  localparam int MEM_DEPTH = 12;
  localparam int PC_INC    = 4;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    BUSCA   = 3'd1,
    ESPERA  = 3'd2,
    ENTREGA = 3'd3,
    PARADO  = 3'd4
  } estado_t;

endpackage
`default_nettype wire

// File: rtl/controle_busca_registrador_pc.sv
`default_nettype none
// ============================================================================
// Module      : registrador_pc
// Description : Program counter register with its next-PC mux
//               (reset / start / increment / redirect). Also exports the
//               incremented PC with its carry so the caller can range-check
//               it, including wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module registrador_pc #(
  parameter int XLEN = controle_busca_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            zera_i,
  input  logic            incrementa_i,
  input  logic            redireciona_i,
  input  logic [XLEN-1:0] alvo_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN:0]   pc_inc_o
);
  import controle_busca_pkg::*;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Extra MSB keeps the carry so a wrap past 2^XLEN is visible upstream.
  assign pc_inc_o = {1'b0, pc_q} + (XLEN+1)'(PC_INC);
  assign pc_o     = pc_q;

  // Next-PC selection; a redirect wins over the sequential increment.
  always_comb begin
    pc_d = pc_q;
    if (redireciona_i) begin
      pc_d = alvo_i & ~(XLEN'(3));
    end else if (zera_i) begin
      pc_d = '0;
    end else if (incrementa_i) begin
      pc_d = pc_inc_o[XLEN-1:0];
    end
  end

  // PC state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/controle_busca.sv
`default_nettype none
// ============================================================================
// Module      : controle_busca
// Description : Instruction fetch controller. Presents a word address to a
//               one-cycle-latency instruction memory, holds the fetched word
//               for the datapath under a valid/ready handshake, follows
//               branch redirects and halts past the end of memory.
// Revision    : 1.0 - initial release
// ============================================================================
module controle_busca #(
  parameter int XLEN      = controle_busca_pkg::XLEN,
  parameter int MEM_DEPTH = controle_busca_pkg::MEM_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            desvio,
  input  logic [XLEN-1:0] alvo_desvio,
  input  logic [XLEN-1:0] instr_mem,
  output logic [XLEN-1:0] end_mem,
  output logic [XLEN-1:0] instrucao,
  output logic [XLEN-1:0] pc_atual,
  output logic            valido,
  input  logic            pronto,
  output logic            fim,
  output logic [15:0]     conta_instr
);
  import controle_busca_pkg::*;

  // First byte address past the end of memory; (XLEN+1) bits so that an
  // increment carrying out of XLEN bits always compares as out of range.
  localparam logic [XLEN:0] LIMITE_BYTES = (XLEN+1)'(MEM_DEPTH * PC_INC);

  estado_t         estado_q;
  estado_t         estado_d;
  logic [XLEN-1:0] pc;
  logic [XLEN:0]   pc_inc;
  logic            zera;
  logic            incrementa;
  logic            redireciona;
  logic            captura;
  logic            conta_en;
  logic            alvo_fora;
  logic            inc_fora;
  logic [XLEN-1:0] instrucao_q;
  logic [XLEN-1:0] pc_atual_q;
  logic [15:0]     conta_q;

  registrador_pc #(
    .XLEN (XLEN)
  ) u_registrador_pc (
    .clk           (clk),
    .reset         (reset),
    .zera_i        (zera),
    .incrementa_i  (incrementa),
    .redireciona_i (redireciona),
    .alvo_i        (alvo_desvio),
    .pc_o          (pc),
    .pc_inc_o      (pc_inc)
  );

  // addr >> 2 >= MEM_DEPTH is the same test as addr >= MEM_DEPTH*4.
  assign alvo_fora = ({1'b0, alvo_desvio} >= LIMITE_BYTES);
  assign inc_fora  = (pc_inc >= LIMITE_BYTES);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= OCIOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state and control decode; a redirect overrides the normal flow.
  always_comb begin
    estado_d    = estado_q;
    zera        = 1'b0;
    incrementa  = 1'b0;
    redireciona = 1'b0;
    captura     = 1'b0;
    conta_en    = 1'b0;
    case (estado_q)
      OCIOSO, PARADO: begin
        if (start) begin
          zera     = 1'b1;
          estado_d = BUSCA;
        end
      end
      BUSCA: begin
        estado_d = ESPERA;
      end
      ESPERA: begin
        captura  = 1'b1;
        estado_d = ENTREGA;
      end
      ENTREGA: begin
        if (pronto) begin
          conta_en   = 1'b1;
          incrementa = 1'b1;
          estado_d   = inc_fora ? PARADO : BUSCA;
        end
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
    // The handshake still counts, but the redirect target replaces pc+4.
    if (desvio && (estado_q == BUSCA || estado_q == ESPERA || estado_q == ENTREGA)) begin
      redireciona = 1'b1;
      incrementa  = 1'b0;
      captura     = 1'b0;
      estado_d    = alvo_fora ? PARADO : BUSCA;
    end
  end

  // Holding register for the instruction handed to the datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      instrucao_q <= '0;
      pc_atual_q  <= '0;
    end else if (captura) begin
      instrucao_q <= instr_mem;
      pc_atual_q  <= pc;
    end
  end

  // Accepted-instruction counter, saturating at all ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      conta_q <= '0;
    end else if (conta_en && (conta_q != 16'hFFFF)) begin
      conta_q <= conta_q + 16'd1;
    end
  end

  assign end_mem     = {2'b00, pc[XLEN-1:2]};
  assign instrucao   = instrucao_q;
  assign pc_atual    = pc_atual_q;
  assign valido      = (estado_q == ENTREGA);
  assign fim         = (estado_q == PARADO);
  assign conta_instr = conta_q;

endmodule
`default_nettype wire

// File: tb/tb_controle_busca.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle_busca
// Description : Self-checking bench for controle_busca: directed scenarios
//               plus a randomized run against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_busca;

  localparam int XLEN      = 32;
  localparam int MEM_DEPTH = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        desvio;
  logic        pronto;
  logic [31:0] alvo_desvio;
  logic [31:0] instr_mem;
  logic [31:0] end_mem;
  logic [31:0] instrucao;
  logic [31:0] pc_atual;
  logic        valido;
  logic        fim;
  logic [15:0] conta_instr;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mem [MEM_DEPTH];

  always #5 clk = ~clk;

  controle_busca #(
    .XLEN      (XLEN),
    .MEM_DEPTH (MEM_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .desvio      (desvio),
    .alvo_desvio (alvo_desvio),
    .instr_mem   (instr_mem),
    .end_mem     (end_mem),
    .instrucao   (instrucao),
    .pc_atual    (pc_atual),
    .valido      (valido),
    .pronto      (pronto),
    .fim         (fim),
    .conta_instr (conta_instr)
  );

  // Synchronous-read instruction memory: data one cycle after the address.
  always @(posedge clk) begin
    instr_mem <= (end_mem < MEM_DEPTH) ? mem[end_mem[3:0]] : 32'hBAD0_BAD0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; desvio = 1'b0; pronto = 1'b0; alvo_desvio = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits (bounded) for valido; ciclos = ticks spent waiting.
  task automatic wait_valido(output bit ok, output int ciclos);
    ciclos = 0;
    while (!valido && ciclos < 12) begin
      tick();
      ciclos++;
    end
    ok = valido;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; desvio = 1'b1; pronto = 1'b1; alvo_desvio = 32'h10;
    tick();
    tick();
    n_vec++;
    if ({valido, fim} !== 2'b00) begin
      n_err++; $display("FAIL reset_flags: valido/fim got %b expected 00", {valido, fim});
    end
    n_vec++;
    if (conta_instr !== 16'd0) begin
      n_err++; $display("FAIL reset_conta: got %h expected 0", conta_instr);
    end
    n_vec++;
    if ({instrucao, pc_atual, end_mem} !== 96'd0) begin
      n_err++; $display("FAIL reset_regs: instr %h pc %h end %h expected all 0", instrucao, pc_atual, end_mem);
    end
    reset = 1'b0; start = 1'b0; desvio = 1'b0; pronto = 1'b0;
  endtask

  task automatic test_sequencial();
    bit ok;
    int c;
    do_reset();
    pronto = 1'b1;
    pulse_start();
    n_vec++;
    if (end_mem !== 32'd0) begin
      n_err++; $display("FAIL seq_end_mem0: got %h expected 0", end_mem);
    end
    for (int k = 0; k < MEM_DEPTH; k++) begin
      wait_valido(ok, c);
      n_vec++;
      if (!ok || c != 2) begin
        n_err++; $display("FAIL seq_latency word %0d: valido=%b after %0d cycles expected 1 after 2", k, ok, c);
      end
      n_vec++;
      if (pc_atual !== 32'(4 * k) || instrucao !== mem[k]) begin
        n_err++; $display("FAIL seq_word %0d: pc %h instr %h expected pc %h instr %h", k, pc_atual, instrucao, 32'(4 * k), mem[k]);
      end
      tick();
    end
    n_vec++;
    if (fim !== 1'b1 || valido !== 1'b0 || conta_instr !== 16'd12) begin
      n_err++; $display("FAIL seq_end: fim %b valido %b conta %0d expected 1 0 12", fim, valido, conta_instr);
    end
    desvio = 1'b1; alvo_desvio = 32'h0;
    tick();
    desvio = 1'b0; pronto = 1'b0;
    n_vec++;
    if (fim !== 1'b1 || valido !== 1'b0) begin
      n_err++; $display("FAIL seq_parado_desvio: fim %b valido %b expected 1 0", fim, valido);
    end
  endtask

  task automatic test_hold();
    bit ok;
    int c;
    do_reset();
    pulse_start();
    for (int k = 0; k < 2; k++) begin
      wait_valido(ok, c);
      pronto = 1'b1;
      tick();
      pronto = 1'b0;
    end
    wait_valido(ok, c);
    n_vec++;
    if (!ok || pc_atual !== 32'h8) begin
      n_err++; $display("FAIL hold_arrive: valido %b pc %h expected 1 00000008", ok, pc_atual);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++;
      if (valido !== 1'b1 || pc_atual !== 32'h8 || instrucao !== mem[2]) begin
        n_err++; $display("FAIL hold_stable cycle %0d: valido %b pc %h instr %h expected 1 8 %h", k, valido, pc_atual, instrucao, mem[2]);
      end
    end
    pronto = 1'b1;
    tick();
    pronto = 1'b0;
    n_vec++;
    if (valido !== 1'b0 || conta_instr !== 16'd3) begin
      n_err++; $display("FAIL hold_accept: valido %b conta %0d expected 0 3", valido, conta_instr);
    end
  endtask

  task automatic test_desvio_espera();
    bit ok;
    int c;
    do_reset();
    pronto = 1'b1;
    pulse_start();
    for (int k = 0; k < 4; k++) tick();
    n_vec++;
    if (valido !== 1'b0 || end_mem !== 32'd1) begin
      n_err++; $display("FAIL desv_esp_pre: valido %b end %h expected 0 1", valido, end_mem);
    end
    desvio = 1'b1; alvo_desvio = 32'h1E;
    tick();
    desvio = 1'b0;
    n_vec++;
    if (valido !== 1'b0 || conta_instr !== 16'd1 || end_mem !== 32'd7) begin
      n_err++; $display("FAIL desv_esp_squash: valido %b conta %0d end %h expected 0 1 7", valido, conta_instr, end_mem);
    end
    wait_valido(ok, c);
    n_vec++;
    if (!ok || pc_atual !== 32'h1C || instrucao !== mem[7]) begin
      n_err++; $display("FAIL desv_esp_target: valido %b pc %h instr %h expected 1 1c %h", ok, pc_atual, instrucao, mem[7]);
    end
    pronto = 1'b0;
  endtask

  task automatic test_desvio_handshake();
    bit ok;
    int c;
    do_reset();
    pulse_start();
    wait_valido(ok, c);
    pronto = 1'b1; desvio = 1'b1; alvo_desvio = 32'h10;
    tick();
    pronto = 1'b0; desvio = 1'b0;
    n_vec++;
    if (valido !== 1'b0 || conta_instr !== 16'd1) begin
      n_err++; $display("FAIL desv_hs_count: valido %b conta %0d expected 0 1", valido, conta_instr);
    end
    wait_valido(ok, c);
    n_vec++;
    if (!ok || pc_atual !== 32'h10 || instrucao !== mem[4]) begin
      n_err++; $display("FAIL desv_hs_target: valido %b pc %h instr %h expected 1 10 %h", ok, pc_atual, instrucao, mem[4]);
    end
  endtask

  task automatic test_desvio_fora();
    bit ok;
    int c;
    do_reset();
    pronto = 1'b1;
    pulse_start();
    wait_valido(ok, c);
    tick();
    pronto = 1'b0; desvio = 1'b1; alvo_desvio = 32'h30;
    tick();
    desvio = 1'b0;
    n_vec++;
    if (fim !== 1'b1 || valido !== 1'b0 || conta_instr !== 16'd1) begin
      n_err++; $display("FAIL desv_fora_halt: fim %b valido %b conta %0d expected 1 0 1", fim, valido, conta_instr);
    end
    pulse_start();
    n_vec++;
    if (fim !== 1'b0) begin
      n_err++; $display("FAIL desv_fora_restart: fim %b expected 0", fim);
    end
    wait_valido(ok, c);
    n_vec++;
    if (!ok || pc_atual !== 32'h0 || instrucao !== mem[0] || conta_instr !== 16'd1) begin
      n_err++; $display("FAIL desv_fora_resume: valido %b pc %h instr %h conta %0d expected 1 0 %h 1", ok, pc_atual, instrucao, conta_instr, mem[0]);
    end
  endtask

  task automatic test_reset_entrega();
    bit ok;
    int c;
    do_reset();
    pulse_start();
    wait_valido(ok, c);
    reset = 1'b1; start = 1'b1; desvio = 1'b1; pronto = 1'b1; alvo_desvio = 32'h10;
    tick();
    reset = 1'b0; start = 1'b0; desvio = 1'b0; pronto = 1'b0;
    n_vec++;
    if ({valido, fim, conta_instr, instrucao, pc_atual, end_mem} !== 114'd0) begin
      n_err++; $display("FAIL rst_entrega: valido %b fim %b conta %0d instr %h pc %h end %h expected all 0", valido, fim, conta_instr, instrucao, pc_atual, end_mem);
    end
    for (int k = 0; k < 3; k++) tick();
    n_vec++;
    if (valido !== 1'b0 || end_mem !== 32'd0 || fim !== 1'b0) begin
      n_err++; $display("FAIL rst_entrega_idle: valido %b end %h fim %b expected 0 0 0", valido, end_mem, fim);
    end
  endtask

  // Randomized run against a transaction model: tracks only the address of
  // the next instruction to deliver, the accepted count and halted state.
  task automatic test_aleatorio();
    logic [31:0] exp_pc;
    logic [31:0] alvo;
    int          cnt;
    bit          ativo;
    bit          parado;
    bit          hs;
    bit          st;
    bit          dv;
    int          sem_valido;
    do_reset();
    exp_pc = '0; cnt = 0; ativo = 1'b0; parado = 1'b0; sem_valido = 0;
    for (int i = 0; i < 3000; i++) begin
      pronto = 1'($urandom % 2);
      dv     = (($urandom % 6) == 0);
      alvo   = (($urandom % 20) == 0) ? 32'hFFFF_FFF0 : 32'($urandom_range(0, 63));
      st     = ativo ? (($urandom % 16) == 0) : (($urandom % 3) == 0);
      start = st; desvio = dv; alvo_desvio = alvo;
      hs = valido && pronto;
      tick();
      if (!ativo) begin
        if (st) begin
          ativo = 1'b1; parado = 1'b0; exp_pc = '0;
        end
      end else begin
        if (hs && cnt < 65535) cnt++;
        if (dv) exp_pc = alvo & ~32'h3;
        else if (hs) exp_pc = exp_pc + 32'd4;
        if ((dv || hs) && ((exp_pc >> 2) >= MEM_DEPTH)) begin
          ativo = 1'b0; parado = 1'b1;
        end
      end
      if (ativo && !valido && !dv) sem_valido++;
      else sem_valido = 0;
      n_vec++;
      if (fim !== parado || conta_instr !== 16'(cnt)) begin
        n_err++; $display("FAIL rand_status cycle %0d: fim %b conta %0d expected %b %0d", i, fim, conta_instr, parado, cnt);
      end
      n_vec++;
      if (valido && (pc_atual !== exp_pc || instrucao !== mem[exp_pc[5:2]])) begin
        n_err++; $display("FAIL rand_deliver cycle %0d: pc %h instr %h expected %h %h", i, pc_atual, instrucao, exp_pc, mem[exp_pc[5:2]]);
      end
      n_vec++;
      if ((!ativo && valido) || sem_valido > 2) begin
        n_err++; $display("FAIL rand_valido cycle %0d: valido %b active %b idle_run %0d expected valido only while active within 2 cycles", i, valido, ativo, sem_valido);
      end
    end
    start = 1'b0; desvio = 1'b0; pronto = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; desvio = 1'b0; pronto = 1'b0; alvo_desvio = '0;
    for (int k = 0; k < MEM_DEPTH; k++) mem[k] = $urandom;
    test_reset();
    test_sequencial();
    test_hold();
    test_desvio_espera();
    test_desvio_handshake();
    test_desvio_fora();
    test_reset_entrega();
    test_aleatorio();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/controle_busca.md
CONTROLE_BUSCA -- requirements
Module: controle_busca

Interface
REQ-001 Parameter XLEN, default 32, shall set the instruction and address width.
REQ-002 Parameter MEM_DEPTH, default 12, shall set the number of instruction words in memory.
REQ-003 clk  input  1  system clock; all state shall update on the posedge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle pulse that begins fetching from byte address 0.
REQ-006 desvio  input  1  branch/jump redirect request from the datapath.
REQ-007 alvo_desvio  input  XLEN  redirect target as a byte address.
REQ-008 instr_mem  input  XLEN  memory read data, valid one cycle after end_mem is presented.
REQ-009 end_mem  output  XLEN  word index to instruction memory, equal to pc[XLEN-1:2].
REQ-010 instrucao  output  XLEN  instruction held for the datapath.
REQ-011 pc_atual  output  XLEN  byte address of instrucao.
REQ-012 valido  output  1  instrucao/pc_atual are valid.
REQ-013 pronto  input  1  datapath accepts the instruction when valido and pronto are both high.
REQ-014 fim  output  1  halted: program end reached or target out of range.
REQ-015 conta_instr  output  16  count of accepted instructions, saturating at 16'hFFFF.

Function
REQ-016 The FSM shall have the states OCIOSO, BUSCA, ESPERA, ENTREGA and PARADO.
REQ-017 OCIOSO: on start, pc <= 0 and the FSM moves to BUSCA; all other inputs are ignored.
REQ-018 BUSCA: end_mem shall show pc[XLEN-1:2] and the FSM moves to ESPERA next cycle.
REQ-019 ESPERA: instrucao <= instr_mem, pc_atual <= pc, valido <= 1, and the FSM moves to ENTREGA.
REQ-020 Latency from entering BUSCA to valido high shall be exactly 2 cycles.
REQ-021 ENTREGA: instrucao, pc_atual and valido shall hold stable while pronto is low.
REQ-022 On handshake, valido <= 0, pc <= pc+4 and conta_instr increments, saturating at its maximum.
REQ-023 After a handshake, the FSM shall enter PARADO if (pc+4)>>2 >= MEM_DEPTH, else BUSCA.
REQ-024 Redirect: in BUSCA, ESPERA or ENTREGA, desvio high shall squash any in-flight or held instruction and force valido <= 0.
REQ-025 On redirect, pc <= alvo_desvio with bits [1:0] forced to 0, and the FSM moves to BUSCA.
REQ-026 If alvo_desvio>>2 >= MEM_DEPTH, the FSM shall enter PARADO instead of BUSCA.
REQ-027 If desvio and a handshake occur in the same cycle, the handshake shall count (conta_instr increments) and the redirect shall set pc; the pc+4 increment is discarded.
REQ-028 desvio shall be ignored in OCIOSO and PARADO.
REQ-029 A start pulse outside OCIOSO and PARADO shall be ignored.
REQ-030 PARADO: fim = 1 and valido = 0; start shall restart as in OCIOSO, clear fim and keep conta_instr.
REQ-031 PC arithmetic is modulo 2^XLEN; the range check in REQ-023 shall catch wrap-around.

Reset
REQ-032 When reset is high at a posedge: state = OCIOSO; pc, end_mem, instrucao, pc_atual = 0; valido, fim = 0; conta_instr = 0.
REQ-033 Reset shall take priority over start, desvio and pronto in the same cycle.
REQ-034 Reset mid-operation shall discard any held instruction with no handshake counted.

Structure
REQ-035 A shared package shall hold the FSM state encoding, XLEN, MEM_DEPTH and the PC increment constant (4).
REQ-036 The PC register with its next-PC mux (reset / start / increment / redirect) shall be one sub-module, registrador_pc.

Verification
REQ-037 reset, then start; pronto held 1; memory holds 12 words -> instrucao shows words 0..11 with pc_atual 0,4,...,44, valido every 3rd cycle, then fim = 1 and conta_instr = 12.
REQ-038 pronto = 0 for 5 cycles while valido = 1 at pc 8 -> instrucao and pc_atual = 8 held stable; one handshake, conta_instr += 1.
REQ-039 desvio = 1 with alvo_desvio = 0x1E while in ESPERA at pc 4 -> word 1 squashed, next valido shows pc_atual = 0x1C (word 7).
REQ-040 desvio plus handshake in the same cycle with alvo_desvio = 0x10 -> conta_instr += 1, next valido shows pc_atual = 0x10.
REQ-041 desvio with alvo_desvio = 0x30 -> fim = 1 and valido = 0 next cycle; then start -> fetch resumes at pc 0.
REQ-042 reset asserted while in ENTREGA with pronto = 0 -> next cycle all outputs 0, state OCIOSO, no count.
